// File: rtl/event_encoder16_pkg.sv
// Shared constants and helpers for the 16-line event encoder.
package event_encoder16_pkg;

  localparam int N  = 16;
  localparam int CW = 4;
  localparam logic [CW-1:0] W_RESET = 4'd0;

  // One-hot mask used to retire the bit that was just loaded into the output register
  function automatic logic [N-1:0] oneHot(input logic [CW-1:0] idx);
    logic [N-1:0] mask;
    mask = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/event_encoder16_lsb.sv
// Combinational 16-to-4 priority encoder; the lowest set bit wins.
module lsb_encoder16
  import event_encoder16_pkg::*;
(
  input  logic [N-1:0]  in_i,
  output logic [CW-1:0] code_o,
  output logic          any_o
);

  // Scan from the top down so the last assignment is the lowest set index
  always_comb begin
    code_o = '0;
    any_o  = |in_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_i[i]) code_o = CW'(i);
    end
  end

endmodule

// File: rtl/event_encoder16.sv
// Sequential 16-to-4 event encoder: pending request set drained one code per cycle over valid/ready.
module event_encoder16
  import event_encoder16_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          En,
  input  logic [N-1:0]  req,
  output logic [CW-1:0] W,
  output logic          valid,
  input  logic          ready,
  output logic          merged,
  output logic          idle
);

  logic [N-1:0]  pending_q, pending_d;
  logic [CW-1:0] w_q, w_d;
  logic          valid_q, valid_d;
  logic          merged_q, merged_d;

  logic [N-1:0]  inV;
  logic [N-1:0]  cand;
  logic [CW-1:0] candCode;
  logic          candAny;
  logic          slotFree;

  assign inV  = En ? req : '0;
  assign cand = pending_q | inV;

  lsb_encoder16 u_lsb (
    .in_i   (cand),
    .code_o (candCode),
    .any_o  (candAny)
  );

  always_comb begin
    pending_d = pending_q;
    w_d       = w_q;
    valid_d   = valid_q;
    merged_d  = |(inV & pending_q);
    slotFree  = !valid_q || ready;

    // A stalled output keeps its code; everything new just accumulates in pending
    if (slotFree) begin
      if (candAny) begin
        w_d       = candCode;
        valid_d   = 1'b1;
        pending_d = cand & ~oneHot(candCode);
      end else begin
        valid_d   = 1'b0;
        pending_d = '0;
      end
    end else begin
      pending_d = cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      w_q       <= W_RESET;
      valid_q   <= 1'b0;
      merged_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      w_q       <= w_d;
      valid_q   <= valid_d;
      merged_q  <= merged_d;
    end
  end

  assign W      = w_q;
  assign valid  = valid_q;
  assign merged = merged_q;
  assign idle   = !valid_q && (pending_q == '0);

endmodule
